// File: rtl/regfile_pkg.sv
// Shared register-file definitions: clear/run state encoding and
// default widths used by the decoder and hazard unit.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous read port: zero register, write bypass
// (port 1 over port 0) and stored value, masked while clearing.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              run,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_stored,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] rd_data
);

  logic is_zero;
  logic hit0;
  logic hit1;

  always_comb begin
    is_zero = (ZERO_REG != 0) && (rd_addr == '0);
    hit1    = (BYPASS != 0) && we1 && (wa1 == rd_addr);
    hit0    = (BYPASS != 0) && we0 && (wa0 == rd_addr);
    rd_data = '0;
    if (!run || is_zero) begin
      rd_data = '0;
    end else if (hit1) begin
      rd_data = wd1;
    end else if (hit0) begin
      rd_data = wd0;
    end else begin
      rd_data = rd_stored;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD async reads, two sync writes,
// and a one-entry-per-cycle clear sweep instead of a parallel reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] r_address,
  output logic [NUM_RD*DATA_W-1:0] o_data,
  input  logic                     w_enable0,
  input  logic [ADDR_W-1:0]        w_address0,
  input  logic [DATA_W-1:0]        w_data0,
  input  logic                     w_enable1,
  input  logic [ADDR_W-1:0]        w_address1,
  input  logic [DATA_W-1:0]        w_data1,
  output logic                     o_ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ONE = 1;

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] clr_idx_q;
  logic [ADDR_W-1:0] clr_idx_d;
  logic              clr_we;
  logic              run;
  logic              wr0;
  logic              wr1;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign run     = (state_q == ST_RUN);
  assign o_ready = run;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_we    = 1'b1;
      clr_idx_d = clr_idx_q + IDX_ONE;
      if (clr_idx_q == '1) begin
        state_d = ST_RUN;
      end
    end
  end

  // Port 1 wins a same-address collision, so port 0 is suppressed.
  always_comb begin
    wr1 = run && w_enable1 &&
          !((ZERO_REG != 0) && (w_address1 == '0));
    wr0 = run && w_enable0 &&
          !((ZERO_REG != 0) && (w_address0 == '0)) &&
          !(wr1 && (w_address1 == w_address0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem_q[clr_idx_q] <= '0;
      end else begin
        if (wr0) mem_q[w_address0] <= w_data0;
        if (wr1) mem_q[w_address1] <= w_data1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;

    assign addr   = r_address[k*ADDR_W +: ADDR_W];
    assign stored = mem_q[addr];

    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .run       (run),
      .rd_addr   (addr),
      .rd_stored (stored),
      .we0       (w_enable0),
      .wa0       (w_address0),
      .wd0       (w_data0),
      .we1       (w_enable1),
      .wa1       (w_address1),
      .wd1       (w_data1),
      .rd_data   (o_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default instance plus a
// no-bypass / no-zero-register instance on shared stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  r_address;
  logic        w_enable0;
  logic [4:0]  w_address0;
  logic [31:0] w_data0;
  logic        w_enable1;
  logic [4:0]  w_address1;
  logic [31:0] w_data1;
  logic [63:0] od_a;
  logic [63:0] od_b;
  logic        rdy_a;
  logic        rdy_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp dut_a (
    .clk        (clk),
    .rst        (rst),
    .r_address  (r_address),
    .o_data     (od_a),
    .w_enable0  (w_enable0),
    .w_address0 (w_address0),
    .w_data0    (w_data0),
    .w_enable1  (w_enable1),
    .w_address1 (w_address1),
    .w_data1    (w_data1),
    .o_ready    (rdy_a)
  );

  regfile_mp #(
    .ZERO_REG (0),
    .BYPASS   (0)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .r_address  (r_address),
    .o_data     (od_b),
    .w_enable0  (w_enable0),
    .w_address0 (w_address0),
    .w_data0    (w_data0),
    .w_enable1  (w_enable1),
    .w_address1 (w_address1),
    .w_data1    (w_data1),
    .o_ready    (rdy_b)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] b0;
    logic [31:0] b1;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    w_enable0  = 1'b0;
    w_address0 = '0;
    w_data0    = '0;
    w_enable1  = 1'b0;
    w_address1 = '0;
    w_data1    = '0;
  endtask

  // Called right after the rst edge with rst already low.
  task automatic sweep(input string tag);
    int n;
    n = 0;
    while (!rdy_a && n < 100) begin
      r_address = {5'd9, n[4:0]};
      #1;
      chk({tag, " sweep a0"}, od_a[31:0], 32'h0);
      chk({tag, " sweep a1"}, od_a[63:32], 32'h0);
      chk({tag, " sweep b0"}, od_b[31:0], 32'h0);
      chk({tag, " sweep rdy_b"}, {31'b0, rdy_b}, 32'h0);
      n++;
      tick();
    end
    chk({tag, " sweep len"}, n, 32);
    chk({tag, " rdy_a end"}, {31'b0, rdy_a}, 32'h1);
    chk({tag, " rdy_b end"}, {31'b0, rdy_b}, 32'h1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0,
                 5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    vecs[1]  = '{0, 0,  0, 0, 0, 0,
                 5, 0,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    vecs[2]  = '{1, 7,  32'h11111111, 1, 7, 32'h22222222,
                 7, 7,  32'h22222222, 32'h22222222, 0, 0};
    vecs[3]  = '{0, 0,  0, 0, 0, 0,
                 7, 5,  32'h22222222, 32'hDEADBEEF,
                 32'h22222222, 32'hDEADBEEF};
    vecs[4]  = '{1, 0,  32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF,
                 0, 0,  0, 0, 0, 0};
    vecs[5]  = '{0, 0,  0, 0, 0, 0,
                 0, 0,  0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[6]  = '{1, 10, 32'hA, 1, 11, 32'hB,
                 10, 11, 32'hA, 32'hB, 0, 0};
    vecs[7]  = '{0, 0,  0, 0, 0, 0,
                 11, 10, 32'hB, 32'hA, 32'hB, 32'hA};
    vecs[8]  = '{0, 0,  0, 1, 5, 32'hCAFE,
                 5, 7,  32'hCAFE, 32'h22222222,
                 32'hDEADBEEF, 32'h22222222};
    vecs[9]  = '{1, 5,  32'h1234, 0, 0, 0,
                 5, 5,  32'h1234, 32'h1234, 32'hCAFE, 32'hCAFE};
    vecs[10] = '{0, 0,  0, 0, 0, 0,
                 5, 5,  32'h1234, 32'h1234, 32'h1234, 32'h1234};

    rst = 1'b1;
    r_address = '0;
    idle_writes();
    tick();
    chk("rst rdy_a", {31'b0, rdy_a}, 32'h0);
    chk("rst od_a", od_a[31:0], 32'h0);
    rst = 1'b0;

    // Writes to r9 must be ignored while clearing.
    w_enable0  = 1'b1;
    w_address0 = 5'd9;
    w_data0    = 32'hABCD;
    sweep("init");
    idle_writes();
    r_address = {5'd9, 5'd9};
    #1;
    chk("r9 after clear a", od_a[31:0], 32'h0);
    chk("r9 after clear b", od_b[31:0], 32'h0);

    foreach (vecs[i]) begin
      w_enable0  = vecs[i].we0;
      w_address0 = vecs[i].wa0;
      w_data0    = vecs[i].wd0;
      w_enable1  = vecs[i].we1;
      w_address1 = vecs[i].wa1;
      w_data1    = vecs[i].wd1;
      r_address  = {vecs[i].ra1, vecs[i].ra0};
      #1;
      chk($sformatf("vec%0d a0", i), od_a[31:0],  vecs[i].a0);
      chk($sformatf("vec%0d a1", i), od_a[63:32], vecs[i].a1);
      chk($sformatf("vec%0d b0", i), od_b[31:0],  vecs[i].b0);
      chk($sformatf("vec%0d b1", i), od_b[63:32], vecs[i].b1);
      tick();
    end
    idle_writes();

    w_enable0  = 1'b1;
    w_address0 = 5'd3;
    w_data0    = 32'h5;
    tick();
    idle_writes();
    r_address = {5'd3, 5'd3};
    #1;
    chk("r3 run a", od_a[31:0], 32'h5);
    chk("r3 run b", od_b[31:0], 32'h5);

    // Reset in RUN, then again ten cycles into the sweep.
    pulse_rst();
    chk("midrun rdy", {31'b0, rdy_a}, 32'h0);
    repeat (10) tick();
    chk("midsweep rdy", {31'b0, rdy_a}, 32'h0);
    pulse_rst();
    sweep("restart");
    r_address = {5'd5, 5'd3};
    #1;
    chk("r3 cleared a", od_a[31:0], 32'h0);
    chk("r3 cleared b", od_b[31:0], 32'h0);
    chk("r5 cleared a", od_a[63:32], 32'h0);
    chk("r5 cleared b", od_b[63:32], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined core. Successor to the fixed 32x32, 2R/1W file.
- Provides NUM_RD asynchronous read ports and two synchronous write ports (pipeline writeback plus load/MUL late writeback).
- Adds optional same-cycle write-to-read bypass and an optional hardwired zero register.
- Adds a reset-driven clear sweep that zeroes storage one entry per cycle, so the array maps to RAM without a parallel reset.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth is 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, entry 0 reads as 0 and writes to it are dropped.
- BYPASS, 1, when 1, same-cycle write data is forwarded to matching reads.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- r_address  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- o_data  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
- w_enable0  in  1  write port 0 enable.
- w_address0  in  ADDR_W  write port 0 address.
- w_data0  in  DATA_W  write port 0 data.
- w_enable1  in  1  write port 1 enable (higher priority).
- w_address1  in  ADDR_W  write port 1 address.
- w_data1  in  DATA_W  write port 1 data.
- o_ready  out  1  high when the file is in RUN; low during the clear sweep.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- State machine has two states, CLEAR and RUN, plus a clear counter clr_idx[ADDR_W-1:0].
- Any cycle with rst=1: next state is CLEAR and clr_idx goes to 0.
  - This holds from either state, including mid-sweep, which restarts the sweep.
  - o_ready=0 in the cycles after the rst edge.
- CLEAR state:
  - Each cycle writes 0 to entry clr_idx and increments clr_idx.
  - When clr_idx equals 2**ADDR_W-1 and that entry has been written, the next state is RUN and o_ready=1.
  - The sweep takes exactly 2**ADDR_W cycles after rst deasserts.
  - Both write ports are ignored.
  - All o_data read 0.
- RUN state, writes:
  - Port p writes w_data_p to w_address_p at the rising edge when w_enable_p=1.
  - If ZERO_REG=1 and the address is 0, the write is dropped.
  - If both ports write the same address in one cycle, port 1 wins.
  - Writes to different addresses both commit.
- RUN state, reads:
  - Reads are combinational from r_address.
  - If ZERO_REG=1 and the address is 0, the read returns 0, with no bypass.
  - Otherwise, if BYPASS=1 and w_enable1 is set with w_address1 matching, return w_data1.
  - Otherwise, if BYPASS=1 and w_enable0 is set with w_address0 matching, return w_data0.
  - Otherwise return the stored value.
  - If BYPASS=0, a write becomes visible on reads the cycle after its edge.
- Read ports are fully independent; any number may read the same address.
- Storage is not reset in parallel. Before the first sweep completes, contents are undefined, but reads are masked to 0.
- Outputs after reset: o_ready=0 and o_data=0, until the sweep ends.
- Widths: clr_idx wraps naturally at ADDR_W bits; the terminal compare uses the all-ones value.

Decomposition:
- Shared package regfile_pkg holds:
  - state encoding constants ST_CLEAR=1'b0 and ST_RUN=1'b1;
  - default width constants REG_DATA_W=32 and REG_ADDR_W=5, shared with the decoder and hazard unit.
- One sub-module, regfile_read_port, is natural:
  - It implements the zero/bypass/storage priority mux for one port.
  - It is instantiated NUM_RD times in a generate loop.
  - The clear FSM and storage array stay in regfile_mp.

Test Plan:
- Reset sweep: assert rst for 1 cycle, defaults -> o_ready=0 for exactly 32 cycles and then 1; every address reads 0x00000000 while o_ready=0.
- Basic write/read: write r5=0xDEADBEEF via port 0 -> with BYPASS=1, o_data port 1 reads 0xDEADBEEF in the same cycle with r_address=5; with BYPASS=0, it reads the old value, then 0xDEADBEEF the next cycle.
- Write collision:
  - Port 0 writes r7=0x11111111 and port 1 writes r7=0x22222222 in the same cycle.
  - Bypassed reads return 0x22222222 that cycle.
  - Stored value is 0x22222222 afterwards.
- Zero register: write r0=0xFFFFFFFF on both ports -> r0 reads 0 in the same cycle and afterwards; with ZERO_REG=0, r0 reads 0xFFFFFFFF the next cycle.
- Reset mid-sweep and mid-run:
  - Assert rst at sweep cycle 10 -> the sweep restarts, with o_ready low for 32 more cycles after rst falls.
  - In RUN, write r3=0x5, then assert rst -> r3 reads 0 after the new sweep.
- Writes during CLEAR: drive w_enable0=1, w_address0=9, w_data0=0xABCD during the sweep -> after o_ready=1, r9 reads 0.
